// File: rtl/affine_iter_ctrl.sv
// affine_iter_ctrl: drives x through affine_transform, drops warm-up results, streams the rest out
module affine_iter_ctrl #(
  parameter int PRECISION = 32,
  parameter int ITER_W    = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [PRECISION-1:0] seed0,
  input  logic [PRECISION-1:0] seed1,
  input  logic [PRECISION-1:0] seed2,
  input  logic [ITER_W-1:0]    n_iter,
  input  logic [ITER_W-1:0]    warmup,
  output logic                 at_tvalid,
  output logic [PRECISION-1:0] at_x0,
  output logic [PRECISION-1:0] at_x1,
  output logic [PRECISION-1:0] at_x2,
  input  logic                 at_valid,
  input  logic [PRECISION-1:0] at_xn0,
  input  logic [PRECISION-1:0] at_xn1,
  input  logic [PRECISION-1:0] at_xn2,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [PRECISION-1:0] m_x0,
  output logic [PRECISION-1:0] m_x1,
  output logic [PRECISION-1:0] m_x2,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT, S_DONE} state_t;
  state_t r_state, w_next;
  logic [ITER_W-1:0] r_cnt, r_wcnt, r_n_iter, r_warmup;
  logic [TW-1:0] r_timer;
  logic w_accept, w_timeout, w_more_warm, w_last;
  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_timeout   = (r_state == S_WAIT) && !at_valid && (r_timer == TW'(TIMEOUT - 1));
  assign w_more_warm = r_wcnt < r_warmup;
  assign w_last      = r_cnt == r_n_iter - 1'b1;
  assign at_tvalid   = r_state == S_ISSUE;
  assign done        = r_state == S_DONE;
  assign busy        = r_state != S_IDLE;
  always_ff @(posedge clk)
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (n_iter == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  w_next = at_valid ? (w_more_warm ? S_ISSUE : S_OUT) : (w_timeout ? S_DONE : S_WAIT);
      S_OUT:   if (m_ready) w_next = w_last ? S_DONE : S_ISSUE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      {at_x0, at_x1, at_x2} <= '0;
      {m_x0, m_x1, m_x2}    <= '0;
      m_valid               <= 1'b0;
      err                   <= 1'b0;
      r_cnt                 <= '0;
      r_wcnt                <= '0;
      r_n_iter              <= '0;
      r_warmup              <= '0;
      r_timer               <= '0;
    end else begin
      if (w_accept) begin
        {at_x0, at_x1, at_x2} <= {seed0, seed1, seed2};
        r_cnt                 <= '0;
        r_wcnt                <= '0;
        err                   <= 1'b0;
        r_n_iter              <= n_iter;
        r_warmup              <= warmup;
      end
      if (r_state == S_ISSUE) r_timer <= '0;
      // x only moves on a result, so it stays stable while a transform is outstanding
      if (r_state == S_WAIT && at_valid) begin
        {at_x0, at_x1, at_x2} <= {at_xn0, at_xn1, at_xn2};
        if (w_more_warm) r_wcnt <= r_wcnt + 1'b1;
        else begin
          {m_x0, m_x1, m_x2} <= {at_xn0, at_xn1, at_xn2};
          m_valid            <= 1'b1;
        end
      end
      if (r_state == S_WAIT && !at_valid) r_timer <= r_timer + 1'b1;
      if (w_timeout) err <= 1'b1;
      if (r_state == S_OUT && m_ready) begin
        m_valid <= 1'b0;
        if (!w_last) r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_affine_iter_ctrl.sv
// tb_affine_iter_ctrl: directed checks of affine_iter_ctrl against a 5-cycle x+1 transform model
module tb_affine_iter_ctrl;
  localparam int P  = 32;
  localparam int IW = 16;
  localparam int TO = 8;
  logic clk = 0, reset_n = 0, start = 0, m_ready = 1;
  logic [P-1:0] seed0 = 0, seed1 = 0, seed2 = 0;
  logic [IW-1:0] n_iter = 0, warmup = 0;
  logic at_tvalid, m_valid, busy, done, err, at_valid;
  logic [P-1:0] at_x0, at_x1, at_x2, m_x0, m_x1, m_x2;
  logic [P-1:0] at_xn0 = 0, at_xn1 = 0, at_xn2 = 0;
  logic mdl_valid = 0, late_valid = 0;
  bit model_on = 1;
  int n_checks = 0, n_fail = 0;
  int n_tv = 0, n_done = 0, n_mv = 0, n_viol = 0, n_out = 0, mdl_cnt = 0;
  logic [P-1:0] mx0, mx1, mx2;
  logic [P-1:0] ox0 [64], ox1 [64], ox2 [64];
  assign at_valid = mdl_valid | late_valid;

  affine_iter_ctrl #(.PRECISION(P), .ITER_W(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .seed0(seed0), .seed1(seed1), .seed2(seed2),
    .n_iter(n_iter), .warmup(warmup),
    .at_tvalid(at_tvalid), .at_x0(at_x0), .at_x1(at_x1), .at_x2(at_x2),
    .at_valid(at_valid), .at_xn0(at_xn0), .at_xn1(at_xn1), .at_xn2(at_xn2),
    .m_valid(m_valid), .m_ready(m_ready), .m_x0(m_x0), .m_x1(m_x1), .m_x2(m_x2),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // transform model: result strobe 5 cycles after the issue pulse, each word + 1
  always @(negedge clk) begin
    mdl_valid = 0;
    if (mdl_cnt != 0) begin
      mdl_cnt--;
      if (mdl_cnt == 0) begin
        mdl_valid = 1;
        at_xn0 = mx0 + 1;
        at_xn1 = mx1 + 1;
        at_xn2 = mx2 + 1;
      end
    end
    if (model_on && at_tvalid) begin
      mx0 = at_x0;
      mx1 = at_x1;
      mx2 = at_x2;
      mdl_cnt = 5;
    end
  end

  always @(negedge clk) begin
    if (at_tvalid) n_tv++;
    if (done) n_done++;
    if (m_valid) n_mv++;
    if (at_tvalid && m_valid) n_viol++;
    if (m_valid && m_ready && n_out < 64) begin
      ox0[n_out] = m_x0;
      ox1[n_out] = m_x1;
      ox2[n_out] = m_x2;
      n_out++;
    end
  end

  task automatic run_start(input logic [P-1:0] s0, s1, s2, input logic [IW-1:0] n, w);
    @(negedge clk);
    seed0 = s0; seed1 = s1; seed2 = s2; n_iter = n; warmup = w; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_done: done=%0b after %0d cycles, required 1", done, c);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({at_tvalid, m_valid, busy, done, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00000", {at_tvalid, m_valid, busy, done, err});
    end
    n_checks++;
    if ({at_x0, at_x1, at_x2, m_x0, m_x1, m_x2} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: at_x0=%0h m_x0=%0h required 0", at_x0, m_x0);
    end
    reset_n = 1;
  endtask

  task automatic test_basic(input logic [IW-1:0] w, input int first, input int tv_exp);
    int t0 = n_tv, d0 = n_done, o0 = n_out;
    run_start(1, 2, 3, 3, w);
    wait_done(300);
    n_checks++;
    if (n_out - o0 !== 3) begin
      n_fail++;
      $display("FAIL outputs_w%0d: got %0d vectors required 3", w, n_out - o0);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({ox0[o0+i], ox1[o0+i], ox2[o0+i]} !== {P'(first + i), P'(first + i + 1), P'(first + i + 2)}) begin
        n_fail++;
        $display("FAIL vector_w%0d[%0d]: got (%0d,%0d,%0d) required (%0d,%0d,%0d)", w, i,
                 ox0[o0+i], ox1[o0+i], ox2[o0+i], first + i, first + i + 1, first + i + 2);
      end
    end
    n_checks++;
    if (n_tv - t0 !== tv_exp || n_done - d0 !== 1) begin
      n_fail++;
      $display("FAIL pulses_w%0d: tvalid=%0d done=%0d required %0d and 1", w, n_tv - t0, n_done - d0, tv_exp);
    end
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL end_w%0d: err=%0b busy=%0b required 0 0", w, err, busy);
    end
  endtask

  task automatic test_backpressure;
    int t0 = n_tv, o0 = n_out, bad = 0, c = 0;
    m_ready = 0;
    run_start(10, 20, 30, 2, 0);
    while (!m_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    for (int i = 0; i < 10; i++) begin
      if (m_valid !== 1'b1 || at_tvalid !== 1'b0 || {m_x0, m_x1, m_x2} !== {P'(11), P'(21), P'(31)}) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL hold_stable: %0d unstable cycles required 0", bad);
    end
    m_ready = 1;
    @(negedge clk);
    n_checks++;
    if (at_tvalid !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reissue: at_tvalid=%0b m_valid=%0b required 1 0", at_tvalid, m_valid);
    end
    wait_done(100);
    n_checks++;
    if (n_out - o0 !== 2 || ox0[o0] !== 11 || ox2[o0+1] !== 32) begin
      n_fail++;
      $display("FAIL bp_outputs: n=%0d x0=%0d last_x2=%0d required 2 11 32", n_out - o0, ox0[o0], ox2[o0+1]);
    end
    n_checks++;
    if (n_tv - t0 !== 2) begin
      n_fail++;
      $display("FAIL bp_tvalid: got %0d required 2", n_tv - t0);
    end
  endtask

  task automatic test_timeout;
    int d = 0, d0 = n_done;
    model_on = 0;
    run_start(5, 5, 5, 1, 0);
    n_checks++;
    if (at_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL to_issue: at_tvalid=%0b required 1", at_tvalid);
    end
    while (!done && d < 100) begin
      @(negedge clk);
      d++;
    end
    n_checks++;
    if (d < TO || d > TO + 1 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL to_done: %0d cycles err=%0b required %0d..%0d and 1", d, err, TO, TO + 1);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || err !== 1'b1 || n_done - d0 !== 1) begin
      n_fail++;
      $display("FAIL to_idle: busy=%0b err=%0b done=%0d required 0 1 1", busy, err, n_done - d0);
    end
    model_on = 1;
  endtask

  task automatic test_zero;
    int t0 = n_tv, m0 = n_mv, d0 = n_done, c = 0;
    run_start(1, 1, 1, 0, 0);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %0b required 0", err);
    end
    while (!done && c < 2) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done: done=%0b required 1 within 2 cycles", done);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_tv - t0 !== 0 || n_mv - m0 !== 0 || n_done - d0 !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_run: tvalid=%0d mvalid=%0d done=%0d busy=%0b required 0 0 1 0",
               n_tv - t0, n_mv - m0, n_done - d0, busy);
    end
  endtask

  task automatic test_reset_mid;
    int d0 = n_done;
    model_on = 0;
    run_start(7, 8, 9, 1, 0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: got %0b required 1", busy);
    end
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    late_valid = 1;
    @(negedge clk);
    late_valid = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({at_tvalid, m_valid, busy, done, err} !== 5'b0 || {at_x0, at_x1, at_x2, m_x0} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: flags=%b at_x0=%0h m_x0=%0h required 0", {at_tvalid, m_valid, busy, done, err}, at_x0, m_x0);
    end
    n_checks++;
    if (n_done - d0 !== 0) begin
      n_fail++;
      $display("FAIL mid_done: got %0d pulses required 0", n_done - d0);
    end
    model_on = 1;
  endtask

  task automatic test_start_busy;
    int t0 = n_tv, d0 = n_done, o0 = n_out;
    run_start(100, 200, 300, 1, 0);
    repeat (2) @(negedge clk);
    seed0 = 9; seed1 = 9; seed2 = 9; n_iter = 4; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(100);
    repeat (2) @(negedge clk);
    n_checks++;
    if (n_out - o0 !== 1 || {ox0[o0], ox1[o0], ox2[o0]} !== {P'(101), P'(201), P'(301)}) begin
      n_fail++;
      $display("FAIL busy_start: n=%0d vec=(%0d,%0d,%0d) required 1 (101,201,301)", n_out - o0, ox0[o0], ox1[o0], ox2[o0]);
    end
    n_checks++;
    if (n_tv - t0 !== 1 || n_done - d0 !== 1) begin
      n_fail++;
      $display("FAIL busy_pulses: tvalid=%0d done=%0d required 1 1", n_tv - t0, n_done - d0);
    end
  endtask

  initial begin
    test_reset;
    test_basic(0, 2, 3);
    test_basic(2, 4, 5);
    test_backpressure;
    test_timeout;
    test_zero;
    test_reset_mid;
    test_start_busy;
    n_checks++;
    if (n_viol !== 0) begin
      n_fail++;
      $display("FAIL tvalid_during_mvalid: got %0d required 0", n_viol);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
